wb_writeback_stage: RTL

// - MEM/WB pipeline register and write-back formatter for the 5-stage MIPS core.
// - Captures MEM-stage results, selects ALU or load data, and performs byte/halfword lane select and extension.
// - Drives the register file write port (write_data, write_register, RegWrite, load_mode) and a WB forwarding tap.
// - Keeps a retired-instruction counter.

---
 rtl/wb_writeback_stage_if.sv | 43 ++++
 rtl/wb_writeback_stage.sv | 93 +++++++++
 2 files changed

// File: rtl/wb_writeback_stage_if.sv
// MEM -> WB stage bundle: MEM-side controls/results in, register-file write
// port, forwarding tap and retire counter out.
interface wb_writeback_stage_if #(
  parameter int COUNT_W = 32
);
  logic               stall;
  logic               flush;
  logic               mem_valid;
  logic               mem_reg_write;
  logic               mem_mem_to_reg;
  logic [2:0]         mem_load_type;
  logic [1:0]         mem_byte_off;
  logic [31:0]        mem_alu_result;
  logic [31:0]        mem_read_data;
  logic [4:0]         mem_dest_reg;
  logic [31:0]        write_data;
  logic [5:0]         write_register;
  logic               RegWrite;
  logic [1:0]         load_mode;
  logic               fwd_valid;
  logic [4:0]         fwd_reg;
  logic [31:0]        fwd_data;
  logic               misalign_err;
  logic [COUNT_W-1:0] retired_count;

  // MEM stage / environment side
  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg,
           mem_load_type, mem_byte_off, mem_alu_result, mem_read_data,
           mem_dest_reg,
    input  write_data, write_register, RegWrite, load_mode, fwd_valid,
           fwd_reg, fwd_data, misalign_err, retired_count
  );

  // write-back stage side
  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg,
           mem_load_type, mem_byte_off, mem_alu_result, mem_read_data,
           mem_dest_reg,
    output write_data, write_register, RegWrite, load_mode, fwd_valid,
           fwd_reg, fwd_data, misalign_err, retired_count
  );
endinterface

// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register with load lane-select/extension, register-file
// write enable generation, WB forwarding tap and retired-instruction counter.
module wb_writeback_stage #(
  parameter int COUNT_W    = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_writeback_stage_if.slave  wb
);
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic [1:0]         w_byte_sel;
  logic               w_half_sel;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_fmt;
  logic               w_mis;
  logic               w_mis_v;
  logic               w_we;

  logic               r_valid;
  logic [31:0]        r_data;
  logic [4:0]         r_dest;
  logic               r_we;
  logic               r_mis;
  logic [COUNT_W-1:0] r_cnt;

  // lane selection; big-endian mirrors the byte/half order within the word
  always_comb begin
    w_byte_sel = BIG_ENDIAN ? ~wb.mem_byte_off : wb.mem_byte_off;
    w_half_sel = BIG_ENDIAN ? ~wb.mem_byte_off[1] : wb.mem_byte_off[1];
    w_byte     = wb.mem_read_data[{w_byte_sel, 3'b000} +: 8];
    w_half     = w_half_sel ? wb.mem_read_data[31:16] : wb.mem_read_data[15:0];
  end

  // result select, extension and alignment check (loads only)
  always_comb begin
    w_fmt = wb.mem_alu_result;
    w_mis = 1'b0;
    if (wb.mem_mem_to_reg) begin
      case (wb.mem_load_type)
        LT_LH:   begin w_fmt = {{16{w_half[15]}}, w_half}; w_mis = wb.mem_byte_off[0]; end
        LT_LHU:  begin w_fmt = {16'h0000, w_half};         w_mis = wb.mem_byte_off[0]; end
        LT_LB:   w_fmt = {{24{w_byte[7]}}, w_byte};
        LT_LBU:  w_fmt = {24'h000000, w_byte};
        default: begin w_fmt = wb.mem_read_data;           w_mis = (wb.mem_byte_off != 2'b00); end
      endcase
    end
    w_mis_v = wb.mem_valid & w_mis;
    w_we    = wb.mem_valid & wb.mem_reg_write & (wb.mem_dest_reg != 5'd0) & ~w_mis;
  end

  // stage register: flush beats stall beats capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_dest  <= '0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else if (wb.flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
    end else if (wb.stall) begin
      r_mis   <= 1'b0;
    end else begin
      r_valid <= wb.mem_valid;
      r_data  <= w_fmt;
      r_dest  <= wb.mem_dest_reg;
      r_we    <= w_we;
      r_mis   <= w_mis_v;
      // misaligned loads never retire; $0 writes and non-writers still do
      if (wb.mem_valid && !w_mis) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign wb.write_data     = r_data;
  assign wb.write_register = {1'b0, r_dest};
  assign wb.RegWrite       = r_we;
  assign wb.load_mode      = 2'b00;
  assign wb.fwd_valid      = r_we;
  assign wb.fwd_reg        = r_dest;
  assign wb.fwd_data       = r_data;
  assign wb.misalign_err   = r_mis;
  assign wb.retired_count  = r_cnt;

endmodule
